// File: rtl/fft_seq_pkg.sv
// Shared types and constants for the FFT frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_seq_pkg;

    // Frame sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CFG    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_UNLOAD = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

    localparam int SAMPLE_W      = 32;
    localparam int CFG_DEFAULT_W = 16;

    // Beat counter width for a frame of len points (at least one bit)
    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/fft_beat_counter.sv
// Counts accepted beats within one frame and flags the final beat.
// Latency: count updates one cycle after the handshake; is_last_o is registered-count compare.
// Backpressure: none; holds while inc_i is low, saturates on the last beat so it never wraps.
module fft_beat_counter
    import fft_seq_pkg::*;
#(
    parameter int LEN = 128
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic is_last_o
);

    localparam int            W    = cnt_width(LEN);
    localparam logic [W-1:0]  LAST = W'(LEN - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance on a handshake until the last beat
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_last_o = (cnt_q == LAST);

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller in front of fft_core: issues config, streams FFT_LEN samples in, drains FFT_LEN results out.
// Latency: CFG one cycle min; LOAD/UNLOAD data paths are pure combinational pass-through; done one cycle after last sink beat.
// Backpressure: valid/ready forwarded straight through; stalls of any length hold counters. Macro FFT_SEQ_TLAST_CHECK_EN adds core tlast checking.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int FFT_LEN = 128,
    parameter int CFG_W   = CFG_DEFAULT_W,
    parameter int DATA_W  = SAMPLE_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [CFG_W-1:0]  cfg_word,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              err_clr,
    input  logic              src_tvalid,
    output logic              src_tready,
    input  logic [DATA_W-1:0] src_tdata,
    output logic              cfg_tvalid,
    input  logic              cfg_tready,
    output logic [CFG_W-1:0]  cfg_tdata,
    output logic              fin_tvalid,
    input  logic              fin_tready,
    output logic [DATA_W-1:0] fin_tdata,
    output logic              fin_tlast,
    input  logic              fout_tvalid,
    output logic              fout_tready,
    input  logic [DATA_W-1:0] fout_tdata,
    input  logic              fout_tlast,
    output logic              snk_tvalid,
    input  logic              snk_tready,
    output logic [DATA_W-1:0] snk_tdata,
    output logic              snk_tlast,
    input  logic              ev_tlast_unexpected,
    input  logic              ev_tlast_missing
);

    seq_state_e       state_q;
    logic [CFG_W-1:0] cfg_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             err_d;

    logic st_cfg;
    logic st_load;
    logic st_unload;
    logic start_acc;
    logic cfg_hs;
    logic fin_hs;
    logic snk_hs;
    logic in_last;
    logic out_last;
    logic tlast_err;

    assign st_cfg    = (state_q == ST_CFG);
    assign st_load   = (state_q == ST_LOAD);
    assign st_unload = (state_q == ST_UNLOAD);
    assign start_acc = (state_q == ST_IDLE) && start;

    // Config channel presents the latched word only while in CFG
    assign cfg_tvalid = st_cfg;
    assign cfg_tdata  = cfg_q;
    assign cfg_hs     = cfg_tvalid && cfg_tready;

    // Producer -> core pass-through, gated to LOAD
    assign fin_tvalid = st_load && src_tvalid;
    assign src_tready = st_load && fin_tready;
    assign fin_tdata  = src_tdata;
    assign fin_tlast  = st_load && in_last;
    assign fin_hs     = fin_tvalid && fin_tready;

    // Core -> sink pass-through, gated to UNLOAD; our count decides tlast
    assign snk_tvalid  = st_unload && fout_tvalid;
    assign fout_tready = st_unload && snk_tready;
    assign snk_tdata   = fout_tdata;
    assign snk_tlast   = st_unload && out_last;
    assign snk_hs      = snk_tvalid && snk_tready;

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

    fft_beat_counter #(
        .LEN (FFT_LEN)
    ) u_in_cnt (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .clr_i     (start_acc),
        .inc_i     (fin_hs),
        .is_last_o (in_last)
    );

    fft_beat_counter #(
        .LEN (FFT_LEN)
    ) u_out_cnt (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .clr_i     (start_acc),
        .inc_i     (snk_hs),
        .is_last_o (out_last)
    );

`ifdef FFT_SEQ_TLAST_CHECK_EN
    // Core's tlast must agree with our beat count on every output transfer
    assign tlast_err = snk_hs && (fout_tlast != out_last);
`else
    logic unused_fout_tlast;
    assign unused_fout_tlast = fout_tlast;
    assign tlast_err         = 1'b0;
`endif

    // Sticky error: any event sets it, clear only takes effect when nothing sets it
    always_comb begin
        err_d = err_q;
        if (ev_tlast_unexpected || ev_tlast_missing || tlast_err) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Error flag register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // Frame FSM with registered busy/done and latched config word
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cfg_q   <= cfg_word;
                        busy_q  <= 1'b1;
                        state_q <= ST_CFG;
                    end
                end
                ST_CFG: begin
                    if (cfg_hs) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (fin_hs && in_last) begin
                        state_q <= ST_UNLOAD;
                    end
                end
                ST_UNLOAD: begin
                    if (snk_hs && out_last) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Frame-level controller placed in front of `fft_core`. It latches a configuration word and issues it on the core's config channel. It then streams exactly `FFT_LEN` samples from a producer into the core, asserting `tlast` on the final sample. Finally it drains `FFT_LEN` results to a downstream sink and reports done/error status to the processor-side register block.

## Interface
- `FFT_LEN`, 128 — points per frame; power of two, 8..65536.
- `CFG_W`, 16 — config word width; matches `fft_core` `s_axis_config_tdata`.
- `DATA_W`, 32 — sample width, `{imag[15:0], real[15:0]}`.
- `aclk  in  1` — single clock.
- `aresetn  in  1` — asynchronous, active-low reset.
- `start  in  1` — one-cycle request to run one frame.
- `cfg_word  in  CFG_W` — config word, latched on accepted `start`.
- `busy  out  1` — high while not IDLE.
- `done  out  1` — one-cycle pulse when a frame completes.
- `err  out  1` — sticky frame-error flag.
- `err_clr  in  1` — clears `err`.
- `src_tvalid in 1`, `src_tready out 1`, `src_tdata in DATA_W` — producer sample stream.
- `cfg_tvalid out 1`, `cfg_tready in 1`, `cfg_tdata out CFG_W` — to core config channel.
- `fin_tvalid out 1`, `fin_tready in 1`, `fin_tdata out DATA_W`, `fin_tlast out 1` — to core data input.
- `fout_tvalid in 1`, `fout_tready out 1`, `fout_tdata in DATA_W`, `fout_tlast in 1` — from core data output.
- `snk_tvalid out 1`, `snk_tready in 1`, `snk_tdata out DATA_W`, `snk_tlast out 1` — to sink.
- `ev_tlast_unexpected in 1`, `ev_tlast_missing in 1` — core event strobes.

## Operation
- States: IDLE, CFG, LOAD, UNLOAD, DONE.
- IDLE: on `start`, latch `cfg_word`, clear both counters, go to CFG. `start` in any other state is ignored.
- CFG: `cfg_tvalid=1`, `cfg_tdata` = latched word. On `cfg_tvalid & cfg_tready`, go to LOAD.
- LOAD: combinational pass-through.
  - `fin_tvalid=src_tvalid`, `src_tready=fin_tready`, `fin_tdata=src_tdata`.
  - `fin_tlast = (in_cnt==FFT_LEN-1)`.
  - `in_cnt` increments on each `fin_tvalid & fin_tready`.
  - The transfer with `in_cnt==FFT_LEN-1` moves the FSM to UNLOAD.
- UNLOAD: pass-through.
  - `snk_tvalid=fout_tvalid`, `fout_tready=snk_tready`, `snk_tdata=fout_tdata`.
  - `snk_tlast = (out_cnt==FFT_LEN-1)`; the sequencer's count is authoritative.
  - `out_cnt` increments per transfer; the last transfer moves the FSM to DONE.
- DONE: `done=1` for one cycle, then IDLE.
- Outside their states, all `*_tvalid` and `*_tready` outputs are 0. Counters are `$clog2(FFT_LEN)` bits and never wrap within a frame.
- `err` is set by `ev_tlast_unexpected` or `ev_tlast_missing` in any state. It is cleared by `err_clr`; set wins if both occur in the same cycle.

## Timing
- Reset values: `busy=0`, `done=0`, `err=0`, all valid/ready/tlast outputs 0, `cfg_tdata=0`, state IDLE, counters 0.
- `start` sampled at cycle t: CFG is active and `busy=1` from t+1.
- Config is the minimum one cycle when `cfg_tready=1`.
- LOAD and UNLOAD add zero latency: data, valid and ready pass through combinationally, with no registers in the data path.
- With all sinks and sources always ready, a frame takes 1 (CFG) + FFT_LEN + core latency + FFT_LEN + 1 (DONE) cycles.
- `done` asserts the cycle after the last sink transfer. `busy` falls in the same cycle `done` falls.
- Reset mid-frame aborts immediately to reset values. No partial frame is replayed.
- Stalls of any length on any channel are legal. Counters hold while stalled.

## Configuration
- `FFT_SEQ_TLAST_CHECK_EN` defined: in UNLOAD, a transfer where `fout_tlast != (out_cnt==FFT_LEN-1)` also sets `err`. The frame still completes on the count.
- Undefined: `fout_tlast` is ignored; `err` is set only from the event inputs.

## Structure
- `fft_seq_pkg` holds:
  - the state enum (IDLE, CFG, LOAD, UNLOAD, DONE);
  - `SAMPLE_W=32`, `CFG_DEFAULT_W=16`;
  - a function returning the counter width from `FFT_LEN`.
- Sub-module `fft_beat_counter` (clear, increment-on-handshake, `is_last` output) is instantiated twice, for `in_cnt` and `out_cnt`.

## Test plan
- Reset, then `start` with `cfg_word=16'h0001` and all ready → CFG lasts one cycle with `cfg_tdata=16'h0001`. Exactly 128 input beats follow, with `fin_tlast` only on beat 128. After 128 sink beats, `done` pulses once and `err=0`.
- Randomly deassert `src_tvalid`, `fin_tready` and `snk_tready` (~30%) → still exactly 128 beats each way, data order preserved, `done` once.
- `start` pulsed during LOAD → ignored; the frame count and latched config are unchanged.
- Pulse `ev_tlast_missing` during LOAD → `err=1` and stays set; `err_clr` → 0. Simultaneous event and clear → `err=1`.
- With `FFT_SEQ_TLAST_CHECK_EN`, drive `fout_tlast` on beat 100 → `err=1`, and the frame still ends on beat 128. Without the macro → `err=0`.
- Assert `aresetn` low during UNLOAD at beat 50 → all outputs 0 and state IDLE. The next `start` runs a clean full frame.
